// File: rtl/fp_square_if.sv
// Single-precision squarer handshake bundle.
// Operand channel (input_a*) and result channel (output_z*), stb/ack style.
interface fp_square_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

// File: rtl/fp_square.sv
// IEEE-754 single squarer z = a*a, sequential shift-add mantissa multiply.
// Define FP_SQUARE_SUBNORM_OUT_EN for subnormal results instead of flush-to-zero.
module fp_square #(
  parameter int ITER_BITS = 4
) (
  input logic   CLK,
  input logic   RST,
  fp_square_if.slave io
);

  localparam int NCYC = 24 / ITER_BITS;

  typedef enum logic [3:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    MULT,
    NORM,
    DENORM,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       a_q, a_d;
  logic signed [9:0] ea_q, ea_d;
  logic [23:0]       ma_q, ma_d;
  logic [47:0]       mcand_q, mcand_d;
  logic [23:0]       mplier_q, mplier_d;
  logic [47:0]       prod_q, prod_d;
  logic [4:0]        cnt_q, cnt_d;
  logic signed [9:0] ez_q, ez_d;
  logic [23:0]       mant_q, mant_d;
  logic              g_q, g_d;
  logic              r_q, r_d;
  logic              s_q, s_d;
  logic [31:0]       z_q, z_d;
  logic              stb_q, stb_d;
  logic              ack_q, ack_d;

  logic        in_xfer;
  logic        out_xfer;
  logic [7:0]  exp_a;
  logic [22:0] frac_a;
  logic        is_special;
  logic        mult_last;
  logic [9:0]  ez_bias;
  logic [2:0]  unused_bits;

  assign in_xfer    = ack_q & io.input_a_stb;
  assign out_xfer   = stb_q & io.output_z_ack;
  assign exp_a      = a_q[30:23];
  assign frac_a     = a_q[22:0];
  assign is_special = (exp_a == 8'hFF) || (exp_a == 8'h00);
  assign mult_last  = (cnt_q == 5'(NCYC - 1));
  assign ez_bias    = ez_q + 10'sd127;
  // Squares are always non-negative, so the operand sign is dropped.
  assign unused_bits = {a_q[31], ez_bias[9:8]};

  assign io.input_a_ack  = ack_q;
  assign io.output_z_stb = stb_q;
  assign io.output_z     = z_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= GET_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GET_A:   if (in_xfer) state_d = UNPACK;
      UNPACK:  state_d = is_special ? PUT_Z : SPECIAL;
      SPECIAL: state_d = MULT;
      MULT:    if (mult_last) state_d = NORM;
`ifdef FP_SQUARE_SUBNORM_OUT_EN
      NORM:    state_d = DENORM;
      DENORM: begin
        if (ez_q >= -10'sd126 || ez_q < -10'sd151)
          state_d = ROUND;
      end
`else
      NORM:    state_d = ROUND;
`endif
      ROUND:   state_d = PACK;
      PACK:    state_d = PUT_Z;
      PUT_Z:   if (out_xfer) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_comb begin
    logic [47:0] acc;
    logic [24:0] sum;
    logic        rnd;
    a_d      = a_q;
    ea_d     = ea_q;
    ma_d     = ma_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    ez_d     = ez_q;
    mant_d   = mant_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    z_d      = z_q;
    stb_d    = 1'b0;
    ack_d    = 1'b0;
    acc      = prod_q;
    sum      = {1'b0, mant_q};
    rnd      = 1'b0;
    unique case (state_q)
      GET_A: begin
        ack_d = ~in_xfer;
        if (in_xfer) a_d = io.input_a;
      end
      UNPACK: begin
        ea_d = $signed({2'b00, exp_a}) - 10'sd127;
        ma_d = {1'b1, frac_a};
        if (exp_a == 8'hFF)
          z_d = (frac_a != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
        else if (exp_a == 8'h00)
          z_d = 32'h00000000;
      end
      SPECIAL: begin
        mcand_d  = {24'd0, ma_q};
        mplier_d = ma_q;
        prod_d   = 48'd0;
        cnt_d    = 5'd0;
      end
      MULT: begin
        for (int k = 0; k < ITER_BITS; k++) begin
          if (mplier_q[k]) acc = acc + (mcand_q << k);
        end
        prod_d   = acc;
        mcand_d  = mcand_q << ITER_BITS;
        mplier_d = mplier_q >> ITER_BITS;
        cnt_d    = cnt_q + 5'd1;
      end
      NORM: begin
        ez_d = (ea_q <<< 1) + 10'(prod_q[47]);
        if (prod_q[47]) begin
          mant_d = prod_q[47:24];
          g_d    = prod_q[23];
          r_d    = prod_q[22];
          s_d    = |prod_q[21:0];
        end else begin
          mant_d = prod_q[46:23];
          g_d    = prod_q[22];
          r_d    = prod_q[21];
          s_d    = |prod_q[20:0];
        end
      end
`ifdef FP_SQUARE_SUBNORM_OUT_EN
      DENORM: begin
        if (ez_q < -10'sd151) begin
          mant_d = 24'd0;
          g_d    = 1'b0;
          r_d    = 1'b0;
          s_d    = 1'b0;
          ez_d   = -10'sd126;
        end else if (ez_q < -10'sd126) begin
          mant_d = mant_q >> 1;
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = s_q | r_q;
          ez_d   = ez_q + 10'sd1;
        end
      end
`endif
      ROUND: begin
        rnd = g_q & (r_q | s_q | mant_q[0]);
        sum = {1'b0, mant_q} + 25'(rnd);
        if (sum[24]) begin
          mant_d = sum[24:1];
          ez_d   = ez_q + 10'sd1;
        end else begin
          mant_d = sum[23:0];
        end
      end
      PACK: begin
        stb_d = 1'b1;
        if (ez_q > 10'sd127)
          z_d = 32'h7F800000;
        else if (ez_q < -10'sd126)
          z_d = 32'h00000000;
        else if (mant_q[23])
          z_d = {1'b0, ez_bias[7:0], mant_q[22:0]};
        else
          z_d = {9'd0, mant_q[22:0]};
      end
      PUT_Z: begin
        stb_d = ~out_xfer;
        ack_d = out_xfer;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q      <= 32'd0;
      ea_q     <= 10'sd0;
      ma_q     <= 24'd0;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      prod_q   <= 48'd0;
      cnt_q    <= 5'd0;
      ez_q     <= 10'sd0;
      mant_q   <= 24'd0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      z_q      <= 32'd0;
      stb_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      ea_q     <= ea_d;
      ma_q     <= ma_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      ez_q     <= ez_d;
      mant_q   <= mant_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      z_q      <= z_d;
      stb_q    <= stb_d;
      ack_q    <= ack_d;
    end
  end

endmodule
